// File: rtl/systolic_pkg.sv
// Shared defaults and state encoding for the systolic array input feeder.
package systolic_pkg;

  localparam int unsigned N_DEFAULT = 4;
  localparam int unsigned W_DEFAULT = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    FLUSH  = 2'd2,
    DONE   = 2'd3
  } feeder_state_t;

  // Number of zero-injecting advances needed to drain an n x n grid.
  function automatic int unsigned flush_len(input int unsigned n);
    return 2 * n;
  endfunction

endpackage

// File: rtl/skew_line.sv
// DEPTH-stage enabled shift register with async clear; one skew lane of the feeder.
module skew_line #(
  parameter int unsigned DEPTH = 1,
  parameter int unsigned W     = 32
) (
  input  logic         CLK,
  input  logic         RST_N,
  input  logic         adv,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [DEPTH-1:0][W-1:0] stage;

  // Shift only on advance so the lane freezes in lockstep with the PE grid.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      stage <= '0;
    end else if (adv) begin
      stage[0] <= d;
      for (int k = 1; k < int'(DEPTH); k++) begin
        stage[k] <= stage[k-1];
      end
    end
  end

  assign q = stage[DEPTH-1];

endmodule

// File: rtl/systolic_feeder.sv
// Skews A columns / B rows into the west and north edges of an N x N PE array,
// drives the array-wide enable, then drains with zeros and pulses done.
module systolic_feeder
  import systolic_pkg::*;
#(
  parameter int unsigned N = N_DEFAULT,
  parameter int unsigned W = W_DEFAULT
) (
  input  logic           CLK,
  input  logic           RST_N,
  input  logic           s_valid,
  output logic           s_ready,
  input  logic           s_last,
  input  logic [N*W-1:0] s_a,
  input  logic [N*W-1:0] s_b,
  output logic [N*W-1:0] a_out,
  output logic [N*W-1:0] b_out,
  output logic           en,
  output logic           busy,
  output logic           done
);

  localparam int unsigned FLUSH_LEN  = flush_len(N);
  localparam int unsigned CW         = $clog2(FLUSH_LEN + 1);
  localparam logic [CW-1:0] FLUSH_LAST = CW'(FLUSH_LEN - 1);

  feeder_state_t state, state_nxt;
  logic [CW-1:0] flush_cnt, flush_cnt_nxt;
  logic          accept_c;
  logic          flushing_c;
  logic          advance_c;

  assign accept_c   = s_valid & s_ready;
  assign flushing_c = (state == FLUSH);
  assign advance_c  = accept_c | flushing_c;
  assign en         = advance_c;

  // Next-state logic: FLUSH runs exactly FLUSH_LEN advances, DONE lasts one cycle.
  always_comb begin
    state_nxt     = state;
    flush_cnt_nxt = flush_cnt;
    unique case (state)
      IDLE: begin
        if (accept_c) begin
          state_nxt     = s_last ? FLUSH : STREAM;
          flush_cnt_nxt = '0;
        end
      end
      STREAM: begin
        if (accept_c && s_last) begin
          state_nxt     = FLUSH;
          flush_cnt_nxt = '0;
        end
      end
      FLUSH: begin
        if (flush_cnt == FLUSH_LAST) begin
          state_nxt     = DONE;
          flush_cnt_nxt = '0;
        end else begin
          flush_cnt_nxt = flush_cnt + CW'(1);
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt     = IDLE;
        flush_cnt_nxt = '0;
      end
    endcase
  end

  // Status outputs are registered from the next state so they line up with it.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state     <= IDLE;
      flush_cnt <= '0;
      s_ready   <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_nxt;
      flush_cnt <= flush_cnt_nxt;
      s_ready   <= (state_nxt == IDLE) || (state_nxt == STREAM);
      busy      <= (state_nxt == STREAM) || (state_nxt == FLUSH);
      done      <= (state_nxt == DONE);
    end
  end

  // Lane g of A and B gets g+1 stages; FLUSH injects exact zeros.
  for (genvar g = 0; g < int'(N); g++) begin : g_lane
    logic [W-1:0] a_d;
    logic [W-1:0] b_d;

    assign a_d = flushing_c ? '0 : s_a[g*W +: W];
    assign b_d = flushing_c ? '0 : s_b[g*W +: W];

    skew_line #(
      .DEPTH(g + 1),
      .W    (W)
    ) u_a_line (
      .CLK  (CLK),
      .RST_N(RST_N),
      .adv  (advance_c),
      .d    (a_d),
      .q    (a_out[g*W +: W])
    );

    skew_line #(
      .DEPTH(g + 1),
      .W    (W)
    ) u_b_line (
      .CLK  (CLK),
      .RST_N(RST_N),
      .adv  (advance_c),
      .d    (b_d),
      .q    (b_out[g*W +: W])
    );
  end

endmodule

// File: tb/tb_systolic_feeder.sv
// Bench for systolic_feeder: N=2 instance with an attached PE grid, N=4 instance for latency.
module tb_systolic_feeder;

  localparam int unsigned W  = 32;
  localparam int unsigned N2 = 2;
  localparam int unsigned N4 = 4;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;
  logic RST_N;

  logic            v2, last2, ready2, en2, busy2, done2;
  logic [N2*W-1:0] a2, b2, aout2, bout2;
  logic            v4, last4, ready4, en4, busy4, done4;
  logic [N4*W-1:0] a4, b4, aout4, bout4;

  int checks = 0;
  int errors = 0;

  systolic_feeder #(.N(N2), .W(W)) u_dut2 (
    .CLK(CLK), .RST_N(RST_N), .s_valid(v2), .s_ready(ready2), .s_last(last2),
    .s_a(a2), .s_b(b2), .a_out(aout2), .b_out(bout2), .en(en2), .busy(busy2), .done(done2)
  );

  systolic_feeder #(.N(N4), .W(W)) u_dut4 (
    .CLK(CLK), .RST_N(RST_N), .s_valid(v4), .s_ready(ready4), .s_last(last4),
    .s_a(a4), .s_b(b4), .a_out(aout4), .b_out(bout4), .en(en4), .busy(busy4), .done(done4)
  );

  // Attached 2x2 PE grid: A flows east, B flows south, ACC += A*B on EN.
  logic         grid_clr;
  logic [W-1:0] acc2 [N2][N2];
  logic [W-1:0] ea2  [N2][N2];
  logic [W-1:0] sb2  [N2][N2];

  always @(posedge CLK) begin
    logic [W-1:0] ain, bin;
    for (int i = 0; i < int'(N2); i++) begin
      for (int j = 0; j < int'(N2); j++) begin
        if (grid_clr) begin
          acc2[i][j] <= '0;
          ea2[i][j]  <= '0;
          sb2[i][j]  <= '0;
        end else if (en2) begin
          ain = aout2[i*W +: W];
          if (j > 0) ain = ea2[i][j-1];
          bin = bout2[j*W +: W];
          if (i > 0) bin = sb2[i-1][j];
          acc2[i][j] <= acc2[i][j] + ain * bin;
          ea2[i][j]  <= ain;
          sb2[i][j]  <= bin;
        end
      end
    end
  end

  // History of the column/row injected on each advance (beat data or zeros).
  logic [N2*W-1:0] ha2[$];
  logic [N2*W-1:0] hb2[$];

  always @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      ha2.delete();
      hb2.delete();
    end else if (en2) begin
      ha2.push_back((v2 && ready2) ? a2 : '0);
      hb2.push_back((v2 && ready2) ? b2 : '0);
    end
  end

  // Lane i shows the word injected i advances before the most recent one.
  function automatic bit lane_ok2();
    logic [N2*W-1:0] v;
    logic [W-1:0]    ea, eb;
    int n;
    n = ha2.size();
    for (int i = 0; i < int'(N2); i++) begin
      ea = '0;
      eb = '0;
      if (n > i) begin
        v  = ha2[n-1-i];
        ea = v[i*W +: W];
        v  = hb2[n-1-i];
        eb = v[i*W +: W];
      end
      v = aout2;
      if (v[i*W +: W] !== ea) return 1'b0;
      v = bout2;
      if (v[i*W +: W] !== eb) return 1'b0;
    end
    return 1'b1;
  endfunction

  // Job description for the N=2 feeder and observations gathered while driving it.
  int              jn;
  logic [N2*W-1:0] ja [8];
  logic [N2*W-1:0] jb [8];
  int              jgap [8];
  int              done_cyc, stall_en_hi, flush_bad, acc_bad, lane_err;

  function automatic logic [W-1:0] ref_c(input int i, input int j);
    logic [W-1:0]    s;
    logic [N2*W-1:0] va, vb;
    s = '0;
    for (int k = 0; k < jn; k++) begin
      va = ja[k];
      vb = jb[k];
      s  = s + va[i*W +: W] * vb[j*W +: W];
    end
    return s;
  endfunction

  task automatic clear_grid();
    @(negedge CLK);
    grid_clr = 1'b1;
    @(negedge CLK);
    grid_clr = 1'b0;
  endtask

  task automatic drive_job2();
    done_cyc    = -1;
    stall_en_hi = 0;
    flush_bad   = 0;
    acc_bad     = 0;
    lane_err    = 0;
    for (int k = 0; k < jn; k++) begin
      for (int g = 0; g < jgap[k]; g++) begin
        @(negedge CLK);
        if (!lane_ok2()) lane_err++;
        v2 = 1'b0;
        last2 = 1'($urandom_range(0, 1));
        #1;
        if (en2) stall_en_hi++;
      end
      @(negedge CLK);
      if (!lane_ok2()) lane_err++;
      v2 = 1'b1; a2 = ja[k]; b2 = jb[k]; last2 = (k == jn - 1);
      #1;
      if (!en2 || !ready2) acc_bad++;
    end
    for (int c = 1; c <= 60; c++) begin
      @(negedge CLK);
      if (!lane_ok2()) lane_err++;
      v2 = 1'b0;
      last2 = 1'b0;
      #1;
      if (done2) begin
        done_cyc = c;
        break;
      end
      if (!en2 || !busy2) flush_bad++;
    end
  endtask

  task automatic test_reset();
    RST_N = 1'b0;
    repeat (3) @(negedge CLK);
    RST_N = 1'b1;
    @(negedge CLK);
    #1;
    checks++; if (aout2 !== '0) begin errors++; $display("FAIL reset_a_out got=%h exp=0", aout2); end
    checks++; if (bout2 !== '0) begin errors++; $display("FAIL reset_b_out got=%h exp=0", bout2); end
    checks++; if (en2 !== 1'b0) begin errors++; $display("FAIL reset_en got=%b exp=0", en2); end
    checks++; if (busy2 !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy2); end
    checks++; if (done2 !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", done2); end
    checks++; if (ready2 !== 1'b1) begin errors++; $display("FAIL reset_s_ready got=%b exp=1", ready2); end
    checks++;
    if ({ready4, busy4, done4, en4} !== 4'b1000 || aout4 !== '0 || bout4 !== '0) begin
      errors++; $display("FAIL reset_n4 got=%b exp=1000", {ready4, busy4, done4, en4});
    end
    for (int c = 0; c < 5; c++) begin
      @(negedge CLK);
      last2 = 1'b1;
      #1;
      checks++; if (en2 !== 1'b0) begin errors++; $display("FAIL idle_en cyc=%0d got=%b exp=0", c, en2); end
    end
    last2 = 1'b0;
  endtask

  task automatic test_single_beat();
    logic [W-1:0] exp_c [N2][N2];
    exp_c = '{'{32'd15, 32'd18}, '{32'd20, 32'd24}};
    clear_grid();
    jn = 1; ja[0] = {32'd4, 32'd3}; jb[0] = {32'd6, 32'd5}; jgap[0] = 0;
    drive_job2();
    checks++; if (done_cyc !== 5) begin errors++; $display("FAIL single_done_cycle got=%0d exp=5", done_cyc); end
    checks++; if (flush_bad !== 0) begin errors++; $display("FAIL single_flush_en got=%0d exp=0", flush_bad); end
    checks++; if (acc_bad !== 0) begin errors++; $display("FAIL single_accept got=%0d exp=0", acc_bad); end
    checks++; if (lane_err !== 0) begin errors++; $display("FAIL single_lanes got=%0d exp=0", lane_err); end
    for (int i = 0; i < int'(N2); i++)
      for (int j = 0; j < int'(N2); j++) begin
        checks++;
        if (acc2[i][j] !== exp_c[i][j]) begin
          errors++; $display("FAIL single_c%0d%0d got=%0d exp=%0d", i, j, acc2[i][j], exp_c[i][j]);
        end
      end
    @(negedge CLK);
    #1;
    checks++;
    if ({ready2, busy2, done2} !== 3'b100) begin
      errors++; $display("FAIL single_after_done got=%b exp=100", {ready2, busy2, done2});
    end
  endtask

  task automatic test_two_beat(input int gap);
    logic [W-1:0] exp_c [N2][N2];
    exp_c = '{'{32'd38, 32'd44}, '{32'd48, 32'd56}};
    clear_grid();
    jn = 2;
    ja[0] = {32'd2, 32'd1}; jb[0] = {32'd4, 32'd3}; jgap[0] = 0;
    ja[1] = {32'd6, 32'd5}; jb[1] = {32'd8, 32'd7}; jgap[1] = gap;
    drive_job2();
    checks++; if (done_cyc !== 5) begin errors++; $display("FAIL two_beat_done gap=%0d got=%0d exp=5", gap, done_cyc); end
    checks++; if (stall_en_hi !== 0) begin errors++; $display("FAIL stall_en gap=%0d got=%0d exp=0", gap, stall_en_hi); end
    checks++; if (lane_err !== 0) begin errors++; $display("FAIL two_beat_lanes gap=%0d got=%0d exp=0", gap, lane_err); end
    for (int i = 0; i < int'(N2); i++)
      for (int j = 0; j < int'(N2); j++) begin
        checks++;
        if (acc2[i][j] !== exp_c[i][j]) begin
          errors++; $display("FAIL two_beat_c%0d%0d gap=%0d got=%0d exp=%0d", i, j, gap, acc2[i][j], exp_c[i][j]);
        end
      end
  endtask

  task automatic test_reset_mid_flush();
    logic saw_done;
    saw_done = 1'b0;
    clear_grid();
    @(negedge CLK);
    v2 = 1'b1; a2 = {32'd9, 32'd7}; b2 = {32'd11, 32'd13}; last2 = 1'b1;
    @(negedge CLK);
    v2 = 1'b0; last2 = 1'b0;
    @(negedge CLK);
    RST_N = 1'b0;
    #1;
    checks++;
    if (aout2 !== '0 || bout2 !== '0) begin
      errors++; $display("FAIL midflush_lines got=%h/%h exp=0", aout2, bout2);
    end
    checks++;
    if ({ready2, busy2, en2} !== 3'b100) begin
      errors++; $display("FAIL midflush_state got=%b exp=100", {ready2, busy2, en2});
    end
    for (int c = 0; c < 3; c++) begin
      @(negedge CLK);
      if (c == 1) RST_N = 1'b1;
      #1;
      if (done2) saw_done = 1'b1;
    end
    repeat (6) begin
      @(negedge CLK);
      if (done2) saw_done = 1'b1;
    end
    checks++; if (saw_done !== 1'b0) begin errors++; $display("FAIL midflush_no_done got=%b exp=0", saw_done); end
    test_single_beat();
  endtask

  task automatic test_n4_latency();
    int              dc;
    logic [N4*W-1:0] tmp;
    logic [W-1:0]    w3  [13];
    logic [W-1:0]    bw3 [13];
    dc = -1;
    @(negedge CLK);
    v4 = 1'b1; a4 = {N4{32'd1}}; b4 = {N4{32'd1}}; last4 = 1'b1;
    #1;
    checks++; if (en4 !== 1'b1) begin errors++; $display("FAIL n4_accept_en got=%b exp=1", en4); end
    for (int c = 1; c <= 12; c++) begin
      @(negedge CLK);
      v4 = 1'b0; last4 = 1'b0;
      tmp = aout4; w3[c]  = tmp[3*W +: W];
      tmp = bout4; bw3[c] = tmp[3*W +: W];
      if (done4 && dc < 0) dc = c;
    end
    checks++; if (w3[3] !== 32'd0) begin errors++; $display("FAIL n4_a3_early got=%0d exp=0", w3[3]); end
    checks++; if (w3[4] !== 32'd1) begin errors++; $display("FAIL n4_a3_on_time got=%0d exp=1", w3[4]); end
    checks++; if (w3[5] !== 32'd0) begin errors++; $display("FAIL n4_a3_late got=%0d exp=0", w3[5]); end
    checks++; if (bw3[4] !== 32'd1) begin errors++; $display("FAIL n4_b3_on_time got=%0d exp=1", bw3[4]); end
    checks++; if (dc !== 9) begin errors++; $display("FAIL n4_done_cycle got=%0d exp=9", dc); end
  endtask

  task automatic test_random_jobs();
    logic [N2*W-1:0] va, vb;
    logic [W-1:0]    e;
    for (int job = 0; job < 4; job++) begin
      clear_grid();
      jn = int'($urandom_range(1, 5));
      for (int k = 0; k < jn; k++) begin
        for (int i = 0; i < int'(N2); i++) begin
          va[i*W +: W] = W'($urandom_range(0, 65535));
          vb[i*W +: W] = W'($urandom_range(0, 65535));
        end
        ja[k] = va;
        jb[k] = vb;
        jgap[k] = int'($urandom_range(0, 2));
      end
      drive_job2();
      checks++; if (done_cyc !== 5) begin errors++; $display("FAIL rnd_done job=%0d got=%0d exp=5", job, done_cyc); end
      checks++; if (lane_err !== 0) begin errors++; $display("FAIL rnd_lanes job=%0d got=%0d exp=0", job, lane_err); end
      checks++;
      if (stall_en_hi + flush_bad + acc_bad !== 0) begin
        errors++; $display("FAIL rnd_en job=%0d got=%0d exp=0", job, stall_en_hi + flush_bad + acc_bad);
      end
      for (int i = 0; i < int'(N2); i++)
        for (int j = 0; j < int'(N2); j++) begin
          e = ref_c(i, j);
          checks++;
          if (acc2[i][j] !== e) begin
            errors++; $display("FAIL rnd_c%0d%0d job=%0d got=%0d exp=%0d", i, j, job, acc2[i][j], e);
          end
        end
    end
  endtask

  initial begin
    RST_N = 1'b0;
    grid_clr = 1'b0;
    v2 = 1'b0; last2 = 1'b0; a2 = '0; b2 = '0;
    v4 = 1'b0; last4 = 1'b0; a4 = '0; b4 = '0;
    test_reset();
    test_single_beat();
    test_two_beat(0);
    test_two_beat(3);
    test_reset_mid_flush();
    test_n4_latency();
    test_random_jobs();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
